mem_access_unit: RTL

- Multi-cycle load/store sequencer between the datapath and the unified instruction/data memory.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide memory reads and writes. Sub-word stores use read-modify-write.
- Drives the memory's MemRead/MemWrite/addr/write_data ports and consumes its combinational read_data.
- Detects misaligned and illegal accesses and raises the hardware Cause write (causeWrite/cause_code).

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer: word-wide memory reads/writes, RMW for SB/SH,
// misaligned/illegal/Cause-fault trapping. Optional macro: MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter logic [31:0] CAUSE_ADDR       = 32'h0000_0800,
  parameter logic [31:0] CODE_LD_MISALIGN = 32'd4,
  parameter logic [31:0] CODE_LD_FAULT    = 32'd5,
  parameter logic [31:0] CODE_ST_MISALIGN = 32'd6,
  parameter logic [31:0] CODE_ST_FAULT    = 32'd7,
  parameter logic [31:0] CODE_ILLEGAL     = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        cause_write,
  output logic [31:0] cause_code,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, EXC, DONE} state_t;

  state_t      r_state, w_next;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_rword;
  logic [31:0] r_load_data;
  logic [31:0] r_code;
  logic        r_fault;

  logic        w_is_b, w_is_h, w_is_w;
  logic        w_illegal, w_misal, w_cfault, w_exc;
  logic [31:0] w_addr_eff;
  logic [31:0] w_code;
  logic [31:0] w_ext;
  logic [31:0] w_wdata;

  // funct3[1:0] encodes size for both signed and unsigned variants
  assign w_is_b = (funct3[1:0] == 2'b00);
  assign w_is_h = (funct3[1:0] == 2'b01);
  assign w_is_w = (funct3 == 3'b010);

  assign w_illegal = is_store ? !(funct3 inside {3'b000, 3'b001, 3'b010})
                              :  (funct3 inside {3'b011, 3'b110, 3'b111});
  assign w_cfault  = (w_is_b || w_is_h) && (addr_in[31:2] == CAUSE_ADDR[31:2]);

`ifdef MISALIGN_TRAP_EN
  assign w_misal    = (w_is_h && addr_in[0]) || (w_is_w && (addr_in[1:0] != 2'b00));
  assign w_addr_eff = addr_in;
`else
  // Misalignment is silently absorbed by dropping the offending low bits
  assign w_misal    = 1'b0;
  assign w_addr_eff = w_is_w ? {addr_in[31:2], 2'b00} :
                      w_is_h ? {addr_in[31:1], 1'b0}  : addr_in;
`endif

  assign w_exc = w_illegal || w_misal || w_cfault;

  always_comb begin
    w_code = 32'd0;
    if (w_illegal)     w_code = CODE_ILLEGAL;
    else if (w_misal)  w_code = is_store ? CODE_ST_MISALIGN : CODE_LD_MISALIGN;
    else if (w_cfault) w_code = is_store ? CODE_ST_FAULT : CODE_LD_FAULT;
  end

  always_comb begin
    w_ext = mem_rdata;
    case (r_funct3)
      3'b000, 3'b100: begin
        case (r_addr[1:0])
          2'd0:    w_ext = {24'd0, mem_rdata[7:0]};
          2'd1:    w_ext = {24'd0, mem_rdata[15:8]};
          2'd2:    w_ext = {24'd0, mem_rdata[23:16]};
          default: w_ext = {24'd0, mem_rdata[31:24]};
        endcase
        if (!r_funct3[2]) w_ext[31:8] = {24{w_ext[7]}};
      end
      3'b001, 3'b101: begin
        w_ext = r_addr[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
        if (!r_funct3[2]) w_ext[31:16] = {16{w_ext[15]}};
      end
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_wdata = r_sdata;
    case (r_funct3)
      3'b000: begin
        w_wdata = r_rword;
        case (r_addr[1:0])
          2'd0:    w_wdata[7:0]   = r_sdata[7:0];
          2'd1:    w_wdata[15:8]  = r_sdata[7:0];
          2'd2:    w_wdata[23:16] = r_sdata[7:0];
          default: w_wdata[31:24] = r_sdata[7:0];
        endcase
      end
      3'b001: begin
        w_wdata = r_rword;
        if (r_addr[1]) w_wdata[31:16] = r_sdata[15:0];
        else           w_wdata[15:0]  = r_sdata[15:0];
      end
      default: w_wdata = r_sdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) begin
        if (w_exc)                              w_next = EXC;
        else if (is_store && funct3 == 3'b010)  w_next = WRITE;
        else                                    w_next = READ;
      end
      READ:    w_next = r_is_store ? WRITE : DONE;
      WRITE:   w_next = DONE;
      EXC:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_sdata     <= 32'd0;
      r_rword     <= 32'd0;
      r_load_data <= 32'd0;
      r_code      <= 32'd0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_is_store <= is_store;
        r_funct3   <= funct3;
        r_addr     <= w_addr_eff;
        r_sdata    <= store_data;
        r_code     <= w_code;
        r_fault    <= 1'b0;
      end
      if (r_state == READ) begin
        r_rword <= mem_rdata;
        if (!r_is_store) r_load_data <= w_ext;
      end
      if (r_state == EXC) r_fault <= 1'b1;
    end
  end

  always_comb begin
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cause_write = 1'b0;
    cause_code  = 32'd0;
    done        = 1'b0;
    fault       = 1'b0;
    case (r_state)
      READ: begin
        mem_read = 1'b1;
        mem_addr = {r_addr[31:2], 2'b00};
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_wdata = w_wdata;
      end
      EXC: begin
        cause_write = 1'b1;
        cause_code  = r_code;
      end
      DONE: begin
        done  = 1'b1;
        fault = r_fault;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign load_data = r_load_data;

endmodule
